// File: rtl/sub_pkg.sv
// Shared constants and result type for the sign-magnitude subtractor.
package sub_pkg;

  localparam int unsigned SUB_WIDTH = 4;

  typedef struct packed {
    logic                 sign;
    logic [SUB_WIDTH-1:0] mag;
  } sub_result_t;

endpackage

// File: rtl/full_subtractor.sv
// One bit of the ripple-borrow chain.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/sub_4bits.sv
// Registered unsigned subtractor producing |a - b| plus a sign flag (b > a).
module sub_4bits
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH = SUB_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] s,
  output logic             sign,
  output logic             out_valid
);

  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  logic [WIDTH:0]   borrow;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] mag;

  logic [WIDTH-1:0] s_d, s_q;
  logic             sign_d, sign_q;
  logic             out_valid_d, out_valid_q;

  assign borrow[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    full_subtractor u_fs (
      .x    (a[i]),
      .y    (b[i]),
      .bin  (borrow[i]),
      .diff (diff[i]),
      .bout (borrow[i+1])
    );
  end

  // A borrow out of the MSB means the raw difference wrapped; negate it back.
  always_comb begin
    mag = borrow[WIDTH] ? (~diff + One) : diff;
  end

  always_comb begin
    s_d         = s_q;
    sign_d      = sign_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      s_d    = mag;
      sign_d = borrow[WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q         <= '0;
      sign_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s_q         <= s_d;
      sign_q      <= sign_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign s         = s_q;
  assign sign      = sign_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_sub_4bits.sv
// Randomised and directed bench for sub_4bits against an arithmetic model.
module tb_sub_4bits;
  import sub_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] a, b;
  logic [3:0] s;
  logic       sign;
  logic       out_valid;

  int checks = 0;
  int errors = 0;

  sub_result_t m_res;
  logic        m_valid;

  sub_4bits #(
    .WIDTH (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .s         (s),
    .sign      (sign),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: magnitude and sign straight from integer subtraction.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_res   <= '0;
      m_valid <= 1'b0;
    end else begin
      m_valid <= in_valid;
      if (in_valid) begin
        int d;
        d = int'(a) - int'(b);
        m_res.mag  <= 4'(d < 0 ? -d : d);
        m_res.sign <= (d < 0);
      end
    end
  end

  always @(negedge clk) begin
    checks++;
    if ({s, sign, out_valid} !== {m_res.mag, m_res.sign, m_valid}) begin
      errors++;
      $display("FAIL model t=%0t a=%b b=%b got s=%b sign=%b ov=%b want s=%b sign=%b ov=%b",
               $time, a, b, s, sign, out_valid, m_res.mag, m_res.sign, m_valid);
    end
  end

  task automatic check_lit(input string name, input logic [3:0] es, input logic esign,
                           input logic eov);
    checks++;
    if ({s, sign, out_valid} !== {es, esign, eov}) begin
      errors++;
      $display("FAIL %s got s=%b sign=%b ov=%b want s=%b sign=%b ov=%b",
               name, s, sign, out_valid, es, esign, eov);
    end
  endtask

  task automatic apply(input string name, input logic [3:0] ta, input logic [3:0] tb,
                       input logic [3:0] es, input logic esign);
    @(negedge clk);
    a        = ta;
    b        = tb;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    check_lit(name, es, esign, 1'b1);
  endtask

  logic [3:0] st_a [4] = '{4'b0011, 4'b0111, 4'b0111, 4'b1000};
  logic [3:0] st_b [4] = '{4'b0010, 4'b0011, 4'b0110, 4'b0011};
  logic [3:0] st_s [4] = '{4'b0001, 4'b0100, 4'b0001, 4'b0101};

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b1;
    a        = 4'($urandom);
    b        = 4'($urandom);
    #1;
    check_lit("reset_async", 4'b0000, 1'b0, 1'b0);
    repeat (3) begin
      @(negedge clk);
      a = 4'($urandom);
      b = 4'($urandom);
    end
    @(posedge clk);
    #1;
    check_lit("reset_held", 4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b1;

    apply("pos_13_1",  4'b1101, 4'b0001, 4'b1100, 1'b0);
    apply("pos_8_2",   4'b1000, 4'b0010, 4'b0110, 1'b0);
    apply("pos_9_3",   4'b1001, 4'b0011, 4'b0110, 1'b0);
    apply("neg_3_15",  4'b0011, 4'b1111, 4'b1100, 1'b1);
    apply("neg_0_1",   4'b0000, 4'b0001, 4'b0001, 1'b1);
    apply("neg_3_7",   4'b0011, 4'b0111, 4'b0100, 1'b1);
    apply("eq_7_7",    4'b0111, 4'b0111, 4'b0000, 1'b0);
    apply("max_15_0",  4'b1111, 4'b0000, 4'b1111, 1'b0);
    apply("min_0_15",  4'b0000, 4'b1111, 4'b1111, 1'b1);

    // Asynchronous clear between edges, with a valid result on the outputs.
    #2;
    rst_n = 1'b0;
    #1;
    check_lit("reset_mid", 4'b0000, 1'b0, 1'b0);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a        = st_a[i];
      b        = st_b[i];
      in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    a        = 4'($urandom);
    b        = 4'($urandom);
    @(posedge clk);
    #1;
    check_lit("hold", 4'b0101, 1'b0, 1'b0);

    // Re-run the stream to pin each consecutive result against literals.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a        = st_a[i];
      b        = st_b[i];
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      check_lit($sformatf("stream_%0d", i), st_s[i], 1'b0, 1'b1);
    end

    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      a        = 4'(i >> 4);
      b        = 4'(i);
      in_valid = 1'b1;
    end

    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      a        = 4'($urandom);
      b        = 4'($urandom);
      in_valid = 1'($urandom_range(0, 3) != 0);
    end

    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
